// File: rtl/gcm_msg_sequencer.sv
// Sequences one shared AES key-expansion core and the GCM engine
// over a stream of op/key/body command words.
module gcm_msg_sequencer #(
  parameter int BLK_BITS = 128,
  parameter int KEY_BITS = 256,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BLK_BITS-1:0] s_cmd_data,
  input  logic                s_cmd_valid,
  output logic                s_cmd_ready,
  output logic [KEY_BITS-1:0] aes_alg_key,
  output logic                aes_alg_en_key,
  output logic                aes128_mode,
  output logic                aes256_mode,
  input  logic                aes_alg_done,
  output logic                encrypt_flag,
  output logic                decrypt_flag,
  output logic                key_expanded,
  output logic [BLK_BITS-1:0] gcm_in_blk,
  output logic                gcm_valid,
  input  logic                gcm_ready,
  input  logic                gcm_done,
  output logic                busy,
  output logic                err_op,
  output logic [CNT_BITS-1:0] msg_count
);

  typedef enum logic [2:0] {
    S_GET_OP,
    S_KEY0,
    S_KEY1,
    S_EXPAND,
    S_STREAM
  } state_e;

  state_e              state_q;
  logic [KEY_BITS-1:0] key_q;
  logic                en_key_q;
  logic                a128_q;
  logic                a256_q;
  logic                enc_q;
  logic                dec_q;
  logic                kexp_q;
  logic                key_valid_q;
  logic                err_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic hs;
  logic reuse;
  logic k256;
  logic op_bad;

  assign reuse  = s_cmd_data[2];
  assign k256   = s_cmd_data[1];
  // a256_q doubles as the mode of the key held in aes_top
  assign op_bad = (s_cmd_data[7:3] != 5'd0) ||
                  (reuse && (!key_valid_q || (k256 != a256_q)));

  always_comb begin
    s_cmd_ready = 1'b0;
    unique case (state_q)
      S_GET_OP, S_KEY0, S_KEY1: s_cmd_ready = 1'b1;
      S_STREAM: s_cmd_ready = gcm_ready && !gcm_done;
      default:  s_cmd_ready = 1'b0;
    endcase
  end

  assign hs         = s_cmd_valid && s_cmd_ready;
  assign gcm_in_blk = s_cmd_data;
  assign gcm_valid  = (state_q == S_STREAM) && s_cmd_valid && !gcm_done;
  assign busy       = (state_q != S_GET_OP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_GET_OP;
      key_q       <= '0;
      en_key_q    <= 1'b0;
      a128_q      <= 1'b0;
      a256_q      <= 1'b0;
      enc_q       <= 1'b0;
      dec_q       <= 1'b0;
      kexp_q      <= 1'b0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      en_key_q <= 1'b0;
      err_q    <= 1'b0;
      unique case (state_q)
        S_GET_OP: begin
          if (hs) begin
            if (op_bad) begin
              err_q <= 1'b1;
            end else begin
              enc_q  <= s_cmd_data[0];
              dec_q  <= ~s_cmd_data[0];
              a128_q <= ~k256;
              a256_q <= k256;
              if (reuse) begin
                kexp_q  <= 1'b1;
                state_q <= S_STREAM;
              end else begin
                key_valid_q <= 1'b0;
                state_q     <= S_KEY0;
              end
            end
          end
        end
        S_KEY0: begin
          if (hs) begin
            key_q[KEY_BITS-1 -: BLK_BITS] <= s_cmd_data;
            if (a256_q) begin
              state_q <= S_KEY1;
            end else begin
              key_q[BLK_BITS-1:0] <= '0;
              en_key_q            <= 1'b1;
              state_q             <= S_EXPAND;
            end
          end
        end
        S_KEY1: begin
          if (hs) begin
            key_q[BLK_BITS-1:0] <= s_cmd_data;
            en_key_q            <= 1'b1;
            state_q             <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          // a done coincident with the start pulse is stale
          if (aes_alg_done && !en_key_q) begin
            kexp_q      <= 1'b1;
            key_valid_q <= 1'b1;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (gcm_done) begin
            kexp_q  <= 1'b0;
            cnt_q   <= cnt_q + CNT_BITS'(1);
            state_q <= S_GET_OP;
          end
        end
        default: state_q <= S_GET_OP;
      endcase
    end
  end

  assign aes_alg_key    = key_q;
  assign aes_alg_en_key = en_key_q;
  assign aes128_mode    = a128_q;
  assign aes256_mode    = a256_q;
  assign encrypt_flag   = enc_q;
  assign decrypt_flag   = dec_q;
  assign key_expanded   = kexp_q;
  assign err_op         = err_q;
  assign msg_count      = cnt_q;

endmodule

// File: tb/tb_gcm_msg_sequencer.sv
// Scoreboard bench: stub AES/GCM peers, message-level reference model.
module tb_gcm_msg_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] s_cmd_data;
  logic         s_cmd_valid;
  logic         s_cmd_ready;
  logic [255:0] aes_alg_key;
  logic         aes_alg_en_key;
  logic         aes128_mode;
  logic         aes256_mode;
  logic         aes_alg_done;
  logic         encrypt_flag;
  logic         decrypt_flag;
  logic         key_expanded;
  logic [127:0] gcm_in_blk;
  logic         gcm_valid;
  logic         gcm_ready;
  logic         gcm_done;
  logic         busy;
  logic         err_op;
  logic [15:0]  msg_count;

  gcm_msg_sequencer dut (
    .clk(clk), .reset(reset),
    .s_cmd_data(s_cmd_data), .s_cmd_valid(s_cmd_valid),
    .s_cmd_ready(s_cmd_ready),
    .aes_alg_key(aes_alg_key), .aes_alg_en_key(aes_alg_en_key),
    .aes128_mode(aes128_mode), .aes256_mode(aes256_mode),
    .aes_alg_done(aes_alg_done),
    .encrypt_flag(encrypt_flag), .decrypt_flag(decrypt_flag),
    .key_expanded(key_expanded),
    .gcm_in_blk(gcm_in_blk), .gcm_valid(gcm_valid),
    .gcm_ready(gcm_ready), .gcm_done(gcm_done),
    .busy(busy), .err_op(err_op), .msg_count(msg_count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [255:0] key;
    bit           k256;
    bit           enc;
    int           en;
    logic [15:0]  cnt;
  } msg_t;

  msg_t         exp_m[$];
  logic [127:0] exp_q[$];
  int           passed = 0;
  int           total = 0;
  int           body_left = 0;
  bit           done_pending = 0;
  bit           aes_pending = 0;
  bit           aes_clear = 0;
  int           aes_wait = 0;
  int           en_cnt = 0;
  bit           cnt_pending = 0;
  logic [15:0]  cnt_exp = '0;
  bit           kv_m = 0;
  bit           m256_m = 0;
  logic [15:0]  msgs_m = '0;
  int           gap_max = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic fail(input string nm);
    total++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // AES and GCM peer stubs, driven just after each rising edge
  initial begin
    gcm_ready = 1'b0;
    gcm_done = 1'b0;
    aes_alg_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      gcm_ready = ($urandom_range(0, 3) != 0);
      gcm_done = done_pending;
      done_pending = 0;
      aes_alg_done = 1'b0;
      if (aes_clear) begin
        aes_pending = 0;
        aes_clear = 0;
      end
      if (reset) begin
        gcm_done = 1'b0;
        aes_pending = 0;
      end else if (aes_alg_en_key) begin
        aes_pending = 1;
        aes_wait = $urandom_range(1, 4);
        aes_alg_done = 1'($urandom_range(0, 1));
      end else if (aes_pending) begin
        aes_wait--;
        if (aes_wait == 0) begin
          aes_alg_done = 1'b1;
          aes_clear = 1;
        end
      end
    end
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (aes_alg_en_key) begin
        en_cnt++;
        if (exp_m.size() == 0) fail("en_key_unexpected");
        else begin
          chk("aes_key", aes_alg_key, exp_m[0].key);
          chk("aes256_mode", aes256_mode, exp_m[0].k256);
          chk("aes128_mode", aes128_mode, !exp_m[0].k256);
        end
      end
      if (key_expanded) chk("kexp_before_aes_done", aes_pending, 0);
      if (gcm_done) begin
        chk("done_ready_masked", s_cmd_ready, 0);
        chk("done_valid_masked", gcm_valid, 0);
        if (exp_m.size() == 0) fail("gcm_done_unexpected");
        else begin
          msg_t m;
          m = exp_m.pop_front();
          chk("en_key_pulses", en_cnt, m.en);
          cnt_exp = m.cnt;
          cnt_pending = 1;
        end
        en_cnt = 0;
      end else if (cnt_pending) begin
        chk("msg_count", msg_count, cnt_exp);
        cnt_pending = 0;
      end
      if (gcm_valid && gcm_ready) begin
        if (exp_q.size() == 0 || exp_m.size() == 0) fail("gcm_word_unexpected");
        else begin
          chk("gcm_word", gcm_in_blk, exp_q.pop_front());
          chk("kexp_streaming", key_expanded, 1);
          chk("encrypt_flag", encrypt_flag, exp_m[0].enc);
          chk("decrypt_flag", decrypt_flag, !exp_m[0].enc);
          body_left--;
          if (body_left == 0) done_pending = 1;
        end
      end
    end
  end

  task automatic push(input logic [127:0] w);
    bit ok;
    ok = 0;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk); #1;
    end
    s_cmd_data = w;
    s_cmd_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_cmd_ready) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_cmd_valid = 1'b0;
    s_cmd_data = {$urandom, $urandom, $urandom, $urandom};
    if (!ok) fail("push_timeout");
  endtask

  task automatic send_msg(input logic [127:0] op, input logic [127:0] k0,
                          input logic [127:0] k1, input logic [127:0] body[$],
                          input int abort_at);
    bit reuse, k256, bad;
    msg_t m;
    reuse = op[2];
    k256 = op[1];
    bad = (op[7:3] != 5'd0) || (reuse && (!kv_m || (k256 != m256_m)));
    if (bad) begin
      push(op);
      @(negedge clk);
      chk("err_op_pulse", err_op, 1);
      chk("err_stays_idle", busy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_op_one_cycle", err_op, 0);
      @(posedge clk); #1;
      return;
    end
    msgs_m++;
    m.key = k256 ? {k0, k1} : {k0, 128'h0};
    m.k256 = k256;
    m.enc = op[0];
    m.en = reuse ? 0 : 1;
    m.cnt = msgs_m;
    if (!reuse) begin
      kv_m = 1;
      m256_m = k256;
    end
    exp_m.push_back(m);
    foreach (body[i]) exp_q.push_back(body[i]);
    body_left = body.size();
    push(op);
    @(negedge clk);
    chk("kexp_after_op", key_expanded, reuse);
    chk("busy_after_op", busy, 1);
    chk("no_err_valid_op", err_op, 0);
    @(posedge clk); #1;
    if (!reuse) push(k0);
    if (!reuse && k256) push(k1);
    foreach (body[i]) begin
      if (abort_at >= 0 && i == abort_at) break;
      push(body[i]);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (exp_m.size() == 0 && !cnt_pending) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail("wait_idle_timeout");
    @(posedge clk); #1;
  endtask

  logic [127:0] bq[$];
  logic [127:0] op;

  initial begin
    reset = 1'b1;
    s_cmd_valid = 1'b0;
    s_cmd_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", s_cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_key", aes_alg_key, 0);
    chk("rst_modes", {aes128_mode, aes256_mode, aes_alg_en_key}, 0);
    chk("rst_flags", {encrypt_flag, decrypt_flag, key_expanded, err_op}, 0);
    chk("rst_count", msg_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    send_msg(128'h4, '0, '0, bq, -1);
    send_msg(128'h8, '0, '0, bq, -1);

    bq = '{128'h0, 128'h0, 128'h0};
    send_msg(128'h1, '0, '0, bq, -1);
    bq = '{128'h0, 128'h0, 128'h0388dace60b6a392f328c2b971b2fe78};
    send_msg(128'h4, '0, '0, bq, -1);
    send_msg(128'h6, '0, '0, bq, -1);
    bq = '{128'h0, 128'h0, 128'h0};
    send_msg(128'h3, '0, '0, bq, -1);
    wait_idle();

    gap_max = 3;
    for (int n = 0; n < 30; n++) begin
      op = {$urandom, $urandom, $urandom, $urandom};
      op[7:3] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bq.delete();
      repeat ($urandom_range(1, 5)) bq.push_back({$urandom, $urandom, $urandom, $urandom});
      send_msg(op, {$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom}, bq, -1);
    end
    wait_idle();

    bq = '{128'h11, 128'h22, 128'h33, 128'h44, 128'h55, 128'h66};
    send_msg(128'h1, 128'hA5, 128'h0, bq, 2);
    reset = 1'b1;
    exp_m.delete();
    exp_q.delete();
    body_left = 0;
    done_pending = 0;
    en_cnt = 0;
    cnt_pending = 0;
    msgs_m = '0;
    kv_m = 0;
    m256_m = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_kexp", key_expanded, 0);
    chk("rst_mid_gcm_valid", gcm_valid, 0);
    chk("rst_mid_count", msg_count, 0);
    @(posedge clk); #1;
    send_msg(128'h4, '0, '0, bq, -1);
    bq = '{128'h77, 128'h88};
    send_msg(128'h3, 128'hBEEF, 128'hCAFE, bq, -1);
    wait_idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gcm_msg_sequencer.md
Name: gcm_msg_sequencer

Overview:
Synthesizable controller that sequences one shared aes_top core and the gcm engine for a stream of GCM messages.
- Consumes a 128-bit command/data word stream: op word, key word(s), then the GCM input words (IV, AADLEN, AAD, data).
- Drives key expansion, per-message encrypt/decrypt flags and the key_expanded handshake.
- Forwards the message body to gcm until gcm_done.
- Replaces the ad-hoc op/key sequencing currently done in the GCM bench and driver glue.

Parameters:
BLK_BITS, 128, width of command/data words and gcm_in_blk
KEY_BITS, 256, width of aes_alg_key
CNT_BITS, 16, width of the completed-message counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_cmd_data  in  BLK_BITS  command/data word
s_cmd_valid  in  1  word valid
s_cmd_ready  out  1  word accepted when valid&&ready
aes_alg_key  out  KEY_BITS  key to aes_top
aes_alg_en_key  out  1  one-cycle key-expansion start pulse
aes128_mode  out  1  128-bit key mode
aes256_mode  out  1  256-bit key mode
aes_alg_done  in  1  aes_top en_o; sampled only in EXPAND
encrypt_flag  out  1  to gcm
decrypt_flag  out  1  to gcm
key_expanded  out  1  to gcm; key ready for current message
gcm_in_blk  out  BLK_BITS  to gcm
gcm_valid  out  1  to gcm
gcm_ready  in  1  from gcm
gcm_done  in  1  from gcm; message complete
busy  out  1  state != GET_OP
err_op  out  1  one-cycle pulse on rejected op word
msg_count  out  CNT_BITS  completed messages, wraps at 2^CNT_BITS

Behaviour:
- Op word fields:
  - bit0 = encrypt (1) / decrypt (0).
  - bit1 = key256.
  - bit2 = reuse_key.
  - bits[7:3] reserved, must be 0.
  - bits[127:8] ignored.
- States: GET_OP, KEY0, KEY1, EXPAND, STREAM.
- Reset values:
  - State: GET_OP.
  - All 1-bit outputs 0, except s_cmd_ready = 1, which is combinational in GET_OP.
  - aes_alg_key = 0, msg_count = 0.
  - Internal key_valid = 0, key_mode256 = 0.
- Reset mid-message abandons the message with no outputs pending; the upstream source must also restart.
- GET_OP: s_cmd_ready = 1. On handshake:
  - Reserved bits nonzero → err_op pulse next cycle; word dropped; stay GET_OP.
  - reuse_key = 1 with key_valid = 0, or with key256 != key_mode256 → err_op; stay GET_OP.
  - reuse_key = 1 and valid → register flags; key_expanded <= 1; go STREAM (1 cycle, no AES activity).
  - Otherwise → register flags and mode; key_valid <= 0; go KEY0.
- Flag registration: encrypt_flag <= bit0, decrypt_flag <= ~bit0.
- Mode outputs: aes128_mode <= ~bit1, aes256_mode <= bit1. Both hold until the next accepted op.
- KEY0: s_cmd_ready = 1. On handshake, aes_alg_key[255:128] <= word.
  - 128 mode: aes_alg_key[127:0] <= 0, go EXPAND.
  - 256 mode: go KEY1.
- KEY1: s_cmd_ready = 1. On handshake, aes_alg_key[127:0] <= word; go EXPAND.
- EXPAND:
  - s_cmd_ready = 0.
  - aes_alg_en_key = 1 for exactly the first cycle in EXPAND.
  - Wait for aes_alg_done; a done in the same cycle as the en_key pulse is ignored.
  - On aes_alg_done: key_expanded <= 1, key_valid <= 1, go STREAM.
  - No timeout.
- STREAM, combinational pass-through:
  - gcm_in_blk = s_cmd_data.
  - gcm_valid = s_cmd_valid && !gcm_done.
  - s_cmd_ready = gcm_ready && !gcm_done.
  - Masking on gcm_done guarantees the next op word is never swallowed when it arrives in the done cycle.
- On gcm_done in STREAM:
  - key_expanded <= 0.
  - msg_count <= msg_count + 1 (modulo wrap).
  - Go GET_OP.
  - key_valid is retained for later reuse.
- gcm_done outside STREAM is ignored.
- aes_alg_done outside EXPAND is ignored; it is the gcm's cipher completion.
- Outside STREAM: gcm_valid = 0, gcm_in_blk = s_cmd_data (don't-care).
- Latency: op→KEY0 1 cycle; key word→EXPAND 1 cycle; en_key is asserted the cycle EXPAND is entered.

Test Plan:
1. NIST GCM test case 2 (128-bit zero key, zero IV, one zero data block), encrypt:
   - Required: aes_alg_en_key single pulse, aes_alg_key = {0, 0}, aes128_mode = 1.
   - Required: gcm outputs 0388dace60b6a392f328c2b971b2fe78 then tag ab6e47d42cec13bdf53a67b21257bddf.
   - Required: msg_count = 1.
2. Two messages, second with op = 0x4 (reuse, decrypt, 128-bit) using the first message's ciphertext:
   - Required: no en_key pulse for message 2; key_expanded rises 1 cycle after op accept.
   - Required: decrypted data returns the zero block and the tag matches.
3. 256-bit key (NIST case 14, zero key, zero IV, one zero data block):
   - Required: KEY1 visited, aes256_mode = 1, aes_alg_key = 256'h0.
   - Required: ciphertext cea7403d4d606b6e074ec5d3baf39d18, tag d0d1c8a799996bf0265b98b5d48ab919.
4. Error cases:
   - Op = 0x8 → err_op pulse, state stays GET_OP.
   - Op = 0x4 after reset → err_op.
   - Op = 0x6 after a 128-bit key → err_op.
5. Random s_cmd_valid gaps with gcm_ready stalls:
   - Required: no word lost or duplicated.
   - Required: a next-op word presented in the gcm_done cycle is accepted only after return to GET_OP.
6. Reset asserted during STREAM:
   - Required: next cycle busy = 0, key_expanded = 0, gcm_valid = 0, msg_count = 0.
   - Required: a subsequent clean message passes.
